ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit_pkg.sv | 27 ++
 rtl/ifetch_unit_fifo.sv | 73 +++++++
 rtl/ifetch_unit.sv | 151 +++++++++++++++
 tb/tb_ifetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_unit_pkg
// Shared CPU pipeline constants used by the fetch stage:
//   NOP_INSTR      - instruction word presented when no fetched instruction
//                    is available (addi x0,x0,0)
//   ST_BOOT/RUN/DRAIN - fetch controller state encoding
//   fetch_entry_t  - one fetch-queue entry {pc, instruction}
//   word_align()   - clears the byte-offset bits of an address
// ----------------------------------------------------------------------------
package ifetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifetch_unit_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding fetched {pc, instruction} pairs.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   push, push_data   - write an entry (ignored when full)
//   pop               - drop the head entry (ignored when empty)
//   flush             - empty the queue; wins over push and pop
//   head_data         - current head entry (meaningful when count != 0)
//   count             - number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify push/pop against full/empty.
  always_comb begin
    push_ok_s = push && (count_r != CW'(DEPTH));
    pop_ok_s  = pop && (count_r != {CW{1'b0}});
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch stage: issues word-aligned requests to instruction memory,
// queues in-order responses with their PCs and presents them to IF/ID.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   checkpre_flush, redirect_pc - redirect request and its target
//   feedforward_stall          - downstream is not consuming this cycle
//   imem_req_valid/ready/addr  - memory request handshake
//   imem_resp_valid/data       - in-order memory response
//   instrmem_instr_data, instr_addr_o, fetch_valid - output to IF/ID
// Responses for requests issued before a redirect are counted in drop_cnt_r
// and discarded in DRAIN. Requests are only issued in RUN, so every request
// outstanding in RUN belongs to one contiguous address run ending at
// fetch_pc_r; the oldest one's PC is fetch_pc_r - 4*outstanding.
// ----------------------------------------------------------------------------
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        checkpre_flush,
  input  logic [31:0] redirect_pc,
  input  logic        feedforward_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instrmem_instr_data,
  output logic [31:0] instr_addr_o,
  output logic        fetch_valid
);

  localparam int            CW         = $clog2(FQ_DEPTH + 1);
  localparam logic [CW:0]   FQ_DEPTH_W = (CW + 1)'(FQ_DEPTH);

  logic [1:0]    state_r;
  logic [31:0]   fetch_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_cnt_r;

  logic [CW-1:0] fq_count_s;
  logic [CW-1:0] out_after_resp_s;
  logic [CW:0]   inflight_s;
  logic          resp_ok_s;
  logic          req_fire_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   resp_pc_s;
  fetch_entry_t  push_entry_s;
  fetch_entry_t  head_s;

  // Request issue and response qualification.
  always_comb begin
    inflight_s = {1'b0, fq_count_s} + {1'b0, outstanding_r};
    if (rst_n && (state_r == ST_RUN) && !checkpre_flush && (inflight_s < FQ_DEPTH_W)) begin
      imem_req_valid = 1'b1;
    end else begin
      imem_req_valid = 1'b0;
    end
    req_fire_s = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is stray and must not underflow.
    resp_ok_s  = imem_resp_valid && (outstanding_r != {CW{1'b0}});
    if (resp_ok_s) begin
      out_after_resp_s = outstanding_r - CW'(1);
    end else begin
      out_after_resp_s = outstanding_r;
    end
    resp_pc_s         = fetch_pc_r - 32'({outstanding_r, 2'b00});
    push_entry_s.pc   = resp_pc_s;
    push_entry_s.data = imem_resp_data;
    push_s = resp_ok_s && (state_r == ST_RUN) && !checkpre_flush;
    pop_s  = (fq_count_s != {CW{1'b0}}) && !feedforward_stall && !checkpre_flush;
  end

  assign imem_req_addr = fetch_pc_r;

  // Controller state, fetch PC and in-flight bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_BOOT;
      fetch_pc_r    <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      drop_cnt_r    <= {CW{1'b0}};
    end else if (checkpre_flush) begin
      // No request is issued while flushing, so only a response can
      // reduce what is still in flight.
      fetch_pc_r    <= word_align(redirect_pc);
      outstanding_r <= out_after_resp_s;
      drop_cnt_r    <= out_after_resp_s;
      state_r       <= (out_after_resp_s != {CW{1'b0}}) ? ST_DRAIN : ST_RUN;
    end else begin
      case (state_r)
        ST_BOOT:  state_r <= ST_RUN;
        ST_RUN:   state_r <= ST_RUN;
        ST_DRAIN: begin
          if ((drop_cnt_r == {CW{1'b0}}) || (resp_ok_s && (drop_cnt_r == CW'(1)))) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default:  state_r <= ST_BOOT;
      endcase

      if (req_fire_s) fetch_pc_r <= fetch_pc_r + 32'd4;

      case ({req_fire_s, resp_ok_s})
        2'b10:   outstanding_r <= outstanding_r + CW'(1);
        2'b01:   outstanding_r <= outstanding_r - CW'(1);
        default: outstanding_r <= outstanding_r;
      endcase

      if ((state_r == ST_DRAIN) && resp_ok_s && (drop_cnt_r != {CW{1'b0}})) begin
        drop_cnt_r <= drop_cnt_r - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (64)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (checkpre_flush),
    .head_data (head_s),
    .count     (fq_count_s)
  );

  // IF/ID presentation: head of queue, or a NOP bubble when empty.
  always_comb begin
    if (fq_count_s != {CW{1'b0}}) begin
      instrmem_instr_data = head_s.data;
      instr_addr_o        = head_s.pc;
      fetch_valid         = 1'b1;
    end else begin
      instrmem_instr_data = NOP_INSTR;
      instr_addr_o        = 32'd0;
      fetch_valid         = 1'b0;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// ----------------------------------------------------------------------------
// tb_ifetch_unit
// Directed bench for ifetch_unit (default parameters). A small in-order
// memory model answers accepted requests either one cycle later (auto mode)
// or when released by hand. Instruction words are derived from the address
// so every output pair can be checked for pc/data consistency.
// ----------------------------------------------------------------------------
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        checkpre_flush;
  logic [31:0] redirect_pc;
  logic        feedforward_stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instrmem_instr_data;
  logic [31:0] instr_addr_o;
  logic        fetch_valid;

  int          checks;
  int          failures;
  logic        auto_resp;
  logic [31:0] pend [$];

  ifetch_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .checkpre_flush      (checkpre_flush),
    .redirect_pc         (redirect_pc),
    .feedforward_stall   (feedforward_stall),
    .imem_req_valid      (imem_req_valid),
    .imem_req_ready      (imem_req_ready),
    .imem_req_addr       (imem_req_addr),
    .imem_resp_valid     (imem_resp_valid),
    .imem_resp_data      (imem_resp_data),
    .instrmem_instr_data (instrmem_instr_data),
    .instr_addr_o        (instr_addr_o),
    .fetch_valid         (fetch_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: record an accepted request, let the edge pass, then set up
  // the memory response and clear the single-cycle flush pulse.
  task automatic step();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    checkpre_flush = 1'b0;
    if (acc) pend.push_back(a);
    if (auto_resp && (pend.size() > 0)) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(pend.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'd0;
    end
    #1;
  endtask

  task automatic release_resp();
    imem_resp_valid = 1'b1;
    imem_resp_data  = instr_of(pend.pop_front());
  endtask

  // Reset with the memory side; returns in the first RUN cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    checkpre_flush = 1'b0;
    feedforward_stall = 1'b0;
    auto_resp = 1'b1;
    imem_resp_valid = 1'b0;
    step();
    step();
    pend.delete();
    imem_resp_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    checkpre_flush = 1'b0;
    redirect_pc = 32'd0;
    feedforward_stall = 1'b0;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'd0;
    auto_resp = 1'b1;

    // Reset state.
    step();
    step();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_instr", instrmem_instr_data, NOP);
    check("rst_addr", instr_addr_o, 32'd0);
    rst_n = 1'b1;
    #1;
    check("boot_req_valid", {31'd0, imem_req_valid}, 32'd0);
    step();

    // Streaming fetch, 1-cycle memory.
    check("s1_c1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("s1_c1_addr", imem_req_addr, 32'h0);
    step();
    check("s1_c2_fv", {31'd0, fetch_valid}, 32'd0);
    check("s1_c2_addr", imem_req_addr, 32'h4);
    step();
    check("s1_c3_fv", {31'd0, fetch_valid}, 32'd1);
    check("s1_c3_pc", instr_addr_o, 32'h0);
    check("s1_c3_data", instrmem_instr_data, instr_of(32'h0));
    check("s1_c3_req_full", {31'd0, imem_req_valid}, 32'd0);
    step();
    check("s1_c4_pc", instr_addr_o, 32'h4);
    check("s1_c4_data", instrmem_instr_data, instr_of(32'h4));
    check("s1_c4_addr", imem_req_addr, 32'h8);
    step();
    check("s1_c5_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    check("s1_c6_pc", instr_addr_o, 32'h8);

    // Stall for five cycles, release, then flush together with stall.
    do_reset();
    feedforward_stall = 1'b1;
    step();
    step();
    check("s2_c3_pc", instr_addr_o, 32'h0);
    step();
    step();
    check("s2_c5_fv", {31'd0, fetch_valid}, 32'd1);
    check("s2_c5_pc", instr_addr_o, 32'h0);
    check("s2_c5_req_full", {31'd0, imem_req_valid}, 32'd0);
    step();
    feedforward_stall = 1'b0;
    check("s2_c6_pc", instr_addr_o, 32'h0);
    step();
    check("s2_c7_pc", instr_addr_o, 32'h4);
    check("s2_c7_addr", imem_req_addr, 32'h8);
    check("s2_c7_req_valid", {31'd0, imem_req_valid}, 32'd1);
    step();
    check("s2_c8_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    check("s2_c9_pc", instr_addr_o, 32'h8);
    check("s2_c9_data", instrmem_instr_data, instr_of(32'h8));
    feedforward_stall = 1'b1;
    checkpre_flush = 1'b1;
    redirect_pc = 32'h0000_0203;
    step();
    feedforward_stall = 1'b0;
    #1;
    check("s2_fl_fv", {31'd0, fetch_valid}, 32'd0);
    check("s2_fl_instr", instrmem_instr_data, NOP);
    check("s2_fl_addr_o", instr_addr_o, 32'd0);
    check("s2_fl_req_addr", imem_req_addr, 32'h0000_0200);
    check("s2_fl_req_valid", {31'd0, imem_req_valid}, 32'd1);
    step();
    step();
    check("s2_fl_new_pc", instr_addr_o, 32'h0000_0200);

    // Flush with two requests outstanding.
    do_reset();
    auto_resp = 1'b0;
    check("s3_c1_addr", imem_req_addr, 32'h0);
    step();
    check("s3_c2_addr", imem_req_addr, 32'h4);
    step();
    check("s3_c3_req_full", {31'd0, imem_req_valid}, 32'd0);
    checkpre_flush = 1'b1;
    redirect_pc = 32'h0000_0102;
    step();
    check("s3_nop_fv", {31'd0, fetch_valid}, 32'd0);
    check("s3_nop_instr", instrmem_instr_data, NOP);
    check("s3_nop_addr", instr_addr_o, 32'd0);
    check("s3_drain1_req", {31'd0, imem_req_valid}, 32'd0);
    release_resp();
    step();
    check("s3_drain2_req", {31'd0, imem_req_valid}, 32'd0);
    release_resp();
    step();
    check("s3_new_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("s3_new_req_addr", imem_req_addr, 32'h0000_0100);
    check("s3_dropped_fv", {31'd0, fetch_valid}, 32'd0);
    auto_resp = 1'b1;
    step();
    check("s3_c7_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    check("s3_c8_pc", instr_addr_o, 32'h0000_0100);
    check("s3_c8_data", instrmem_instr_data, instr_of(32'h0000_0100));

    // Address wrap at the top of the address space.
    do_reset();
    checkpre_flush = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    check("s4_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("s4_top_valid", {31'd0, imem_req_valid}, 32'd1);
    step();
    check("s4_wrap_addr", imem_req_addr, 32'h0000_0000);
    check("s4_wrap_valid", {31'd0, imem_req_valid}, 32'd1);
    step();
    check("s4_top_pc", instr_addr_o, 32'hFFFF_FFFC);

    // Reset with requests in flight, stray response afterwards.
    do_reset();
    auto_resp = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    check("s5_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("s5_rst_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    pend.delete();
    auto_resp = 1'b1;
    rst_n = 1'b1;
    #1;
    check("s5_boot_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("s5_boot_instr", instrmem_instr_data, NOP);
    step();
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hDEAD_BEEF;
    check("s5_run_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("s5_run_addr", imem_req_addr, 32'h0);
    step();
    check("s5_stray_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    check("s5_first_pc", instr_addr_o, 32'h0);
    check("s5_first_data", instrmem_instr_data, instr_of(32'h0));
    check("s5_first_fv", {31'd0, fetch_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
